// File: rtl/demux1ne2_24_buf_if.sv
// Handshake bundle for the buffered 1-to-2 demux: one source port, two sink ports.
interface demux1ne2_24_buf_if #(parameter int WIDTH = 24);
  logic [WIDTH-1:0] Hyrja;
  logic             S;
  logic             HyrjaValid;
  logic             HyrjaReady;
  logic [WIDTH-1:0] Dalja0;
  logic             Dalja0Valid;
  logic             Dalja0Ready;
  logic [WIDTH-1:0] Dalja1;
  logic             Dalja1Valid;
  logic             Dalja1Ready;

  modport master (
    output Hyrja, S, HyrjaValid, Dalja0Ready, Dalja1Ready,
    input  HyrjaReady, Dalja0, Dalja0Valid, Dalja1, Dalja1Valid
  );

  modport slave (
    input  Hyrja, S, HyrjaValid, Dalja0Ready, Dalja1Ready,
    output HyrjaReady, Dalja0, Dalja0Valid, Dalja1, Dalja1Valid
  );
endinterface

// File: rtl/demux1ne2_24_buf.sv
// Buffered 1-to-2 demux: each destination has its own FIFO so a stalled sink
// never blocks traffic to the other one.
module demux1ne2_24_buf #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input logic               Clock,
  input logic               Reset,
  demux1ne2_24_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [CW-1:0]    count  [2];
  logic [WIDTH-1:0] last   [2];

  logic [1:0] valid;
  logic [1:0] pop;
  logic [1:0] space;
  logic [1:0] push;
  logic [1:0] sink_ready;
  logic       accept;

  assign sink_ready = {bus.Dalja1Ready, bus.Dalja0Ready};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      valid[k] = (count[k] != '0);
      pop[k]   = valid[k] & sink_ready[k];
      // A full FIFO still has room if its head leaves this same cycle.
      space[k] = (count[k] < CW'(DEPTH)) | pop[k];
    end
  end

  assign bus.HyrjaReady = space[bus.S];
  assign accept         = bus.HyrjaValid & bus.HyrjaReady;
  assign push           = {accept & bus.S, accept & ~bus.S};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
        last[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= bus.Hyrja;
          wr_ptr[k]         <= wr_ptr[k] + 1'b1;
        end
        if (pop[k]) begin
          last[k]   <= mem[k][rd_ptr[k]];
          rd_ptr[k] <= rd_ptr[k] + 1'b1;
        end
        if (push[k] && !pop[k])
          count[k] <= count[k] + 1'b1;
        else if (pop[k] && !push[k])
          count[k] <= count[k] - 1'b1;
      end
    end
  end

  // An empty FIFO keeps presenting the word most recently handed to its sink.
  assign bus.Dalja0      = valid[0] ? mem[0][rd_ptr[0]] : last[0];
  assign bus.Dalja1      = valid[1] ? mem[1][rd_ptr[1]] : last[1];
  assign bus.Dalja0Valid = valid[0];
  assign bus.Dalja1Valid = valid[1];
endmodule

// File: tb/tb_demux1ne2_24_buf.sv
// Scoreboard bench for the buffered 1-to-2 demux: directed scenarios followed
// by random traffic, checked against per-output queues.
module tb_demux1ne2_24_buf;
  localparam int WIDTH = 24;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  bit   en;
  int   errors;
  int   checks;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] last0;
  logic [WIDTH-1:0] last1;

  demux1ne2_24_buf_if #(.WIDTH(WIDTH)) bus ();

  demux1ne2_24_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs must match queue heads; handshakes pop the scoreboard.
  always @(negedge clk) begin
    if (en) begin
      check("valid0", {23'd0, bus.Dalja0Valid}, {23'd0, q0.size() != 0});
      check("valid1", {23'd0, bus.Dalja1Valid}, {23'd0, q1.size() != 0});
      if (q0.size() != 0) begin
        check("data0", bus.Dalja0, q0[0]);
        if (bus.Dalja0Ready) last0 = q0.pop_front();
      end else begin
        check("hold0", bus.Dalja0, last0);
      end
      if (q1.size() != 0) begin
        check("data1", bus.Dalja1, q1[0]);
        if (bus.Dalja1Ready) last1 = q1.pop_front();
      end else begin
        check("hold1", bus.Dalja1, last1);
      end
    end
  end

  // Source side: predicts ready from occupancy and records accepted words.
  always @(negedge clk) begin
    #1;
    if (en) begin
      if (rst) begin
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
      end else begin
        bit exp_ready;
        exp_ready = bus.S ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        check("ready", {23'd0, bus.HyrjaReady}, {23'd0, exp_ready});
        if (bus.HyrjaValid && exp_ready) begin
          if (bus.S) q1.push_back(bus.Hyrja);
          else       q0.push_back(bus.Hyrja);
        end
        check("depth0", WIDTH'(q0.size() <= DEPTH), 24'd1);
        check("depth1", WIDTH'(q1.size() <= DEPTH), 24'd1);
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1, input logic r);
    @(posedge clk);
    #1;
    rst            = r;
    bus.HyrjaValid = v;
    bus.S          = s;
    bus.Hyrja      = d;
    bus.Dalja0Ready = r0;
    bus.Dalja1Ready = r1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    en     = 1'b0;
    last0  = '0;
    last1  = '0;
    rst    = 1'b1;
    bus.HyrjaValid  = 1'b0;
    bus.S           = 1'b0;
    bus.Hyrja       = '0;
    bus.Dalja0Ready = 1'b0;
    bus.Dalja1Ready = 1'b0;

    // Two reset cycles; checking starts once the first reset edge has landed.
    @(posedge clk);
    #1;
    en = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1, 0);

    // One word to each sink with both sinks ready.
    drive(1, 0, 24'd5,  1, 1, 0);
    drive(1, 1, 24'd20, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);

    // Fill FIFO 0 against a stalled sink, then release it for one cycle.
    drive(1, 0, 24'd1, 0, 1, 0);
    drive(1, 0, 24'd2, 0, 1, 0);
    drive(1, 0, 24'd3, 0, 1, 0);
    drive(1, 0, 24'd3, 0, 1, 0);
    drive(1, 0, 24'd3, 1, 1, 0);

    // FIFO 0 full and stalled must not block FIFO 1.
    drive(1, 1, 24'd7, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    // Reset with both FIFOs occupied, then make sure nothing stale resurfaces.
    drive(1, 1, 24'd8, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 24'd9, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      drive(r ? 1'b0 : ($urandom_range(0, 3) != 0), 1'($urandom()), WIDTH'($urandom()),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), r);
    end

    for (int i = 0; i < DEPTH + 3; i++) drive(0, 0, 0, 1, 1, 0);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
